scan_bist_ctrl: RTL and testbench
=================================

# scan_bist_ctrl

Logic-BIST sequencer for the scan chain in the DFT wrapper. On a start request it seeds an internal 16-bit pattern LFSR and runs NUM_PATTERNS shift/capture cycles through the scan flop chain. Scan-out data is compacted into a 16-bit MISR, and at the end the signature is compared against a golden value. It sits between the TAP/instruction decode (which issues start and golden_sig) and the scan chain (scan_in/scan_en out, scan_out back).

## Interface
- CHAIN_LEN, 16, scan chain length in flops; must be ≥1
- NUM_PATTERNS, 32, patterns applied per run; must be ≥1
- SEED, 16'hACE1, LFSR load value on reset and on start; must be nonzero
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- golden_sig  input  16  expected MISR signature; sampled in COMPARE
- scan_out  input  1  serial output of the scan chain
- scan_in  output  1  serial input to the scan chain
- scan_en  output  1  1 = shift, 0 = functional capture
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  compare result; held until next accepted start or reset
- signature  output  16  current MISR contents

## Operation
- Reset values: state IDLE, lfsr=SEED, misr=0, all counters 0; scan_in, scan_en, busy, done, pass, signature all 0.
- LFSR: lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; scan_in = lfsr[15] in SHIFT, 0 otherwise. It advances only in SHIFT.
- MISR: misr_next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]^scan_out}. It updates only when enabled (see below); otherwise it holds.
- States:
  - IDLE: waits. When start=1, go to SHIFT; lfsr←SEED, misr←0, pass←0, bit_cnt←0, pat_cnt←0. start is ignored in all other states.
  - SHIFT: scan_en=1; bit_cnt increments. MISR is enabled only when pat_cnt≠0, so the first unload (unknown chain contents) is excluded. When bit_cnt=CHAIN_LEN-1, go to CAPTURE and clear bit_cnt.
  - CAPTURE: one cycle, scan_en=0; pat_cnt increments. Go to FLUSH if the new pat_cnt=NUM_PATTERNS, else go to SHIFT.
  - FLUSH: scan_en=1, scan_in=0, MISR enabled, lfsr held. After CHAIN_LEN cycles go to COMPARE.
  - COMPARE: one cycle, scan_en=0; pass←(misr==golden_sig). Go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Counter widths: bit_cnt is $clog2(CHAIN_LEN+1), pat_cnt is $clog2(NUM_PATTERNS+1). Neither counter wraps within a run.
- signature mirrors misr at all times and is stable from COMPARE until the next accepted start.
- Reset asserted mid-run forces IDLE with all reset values on the next edge. No done pulse is produced, and pass is cleared.

## Timing
- start sampled high at edge T: SHIFT begins in cycle T+1.
- Each pattern takes CHAIN_LEN+1 cycles. FLUSH takes CHAIN_LEN cycles. COMPARE and DONE take one cycle each.
- done is high in cycle T + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 2; busy falls in the next cycle.
- pass is valid from the DONE cycle onward.
- start held high continuously: a new run begins in the cycle after busy falls, i.e. one IDLE cycle between runs.
- All outputs are registered except scan_in, which is a direct tap of lfsr[15] gated by state.

## Configuration
- BIST_ABORT_EN defined: adds input port abort (1 bit). abort=1 in any non-IDLE state forces IDLE on the next edge; done is not pulsed, pass←0, misr and lfsr hold their values. abort in IDLE has no effect. reset has priority over abort.
- BIST_ABORT_EN undefined: no abort port. A run is only terminated early by reset.

## Test plan
- CHAIN_LEN=4, NUM_PATTERNS=2, scan_out tied 0, golden_sig=16'h0000, start pulsed at T → done at T+16, pass=1, signature=16'h0000; scan_en low exactly at T+5, T+10 and T+15.
- Same setup with golden_sig=16'h0001 → done at T+16, pass=0.
- Default parameters, scan chain modeled as a 16-flop shift register capturing its inverted contents, golden_sig taken from the bench reference model → pass=1. Flip one captured bit in pattern 7 → pass=0.
- Reset asserted in cycle T+3 of a run → next cycle busy=0, scan_en=0, pass=0, signature=0; no done pulse.
- start re-pulsed while busy=1 → ignored, done still at T+16 (first config). start held high → second run begins one cycle after busy falls.
- BIST_ABORT_EN defined, abort=1 at T+7 → busy=0 at T+8, no done pulse, pass=0; a subsequent start completes normally.

Source files
------------

// File: rtl/scan_bist_ctrl.sv
// ============================================================================
// scan_bist_ctrl : logic-BIST sequencer (LFSR patterns, scan shift/capture,
//                  MISR compaction, golden compare). Optional BIST_ABORT_EN.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_bist_ctrl #(
   parameter int          CHAIN_LEN    = 16,
   parameter int          NUM_PATTERNS = 32,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] golden_sig,
   input  logic        scan_out,
`ifdef BIST_ABORT_EN
   input  logic        abort,
`endif
   output logic        scan_in,
   output logic        scan_en,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);

   localparam int BIT_W = $clog2(CHAIN_LEN + 1);
   localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
   localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHIFT   = 3'd1,
      S_CAPTURE = 3'd2,
      S_FLUSH   = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [15:0]        misr_q, misr_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
   logic               scan_en_q, scan_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               misr_en;
   logic               abort_req;

`ifdef BIST_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      misr_d    = misr_q;
      bit_cnt_d = bit_cnt_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      misr_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SHIFT;
               lfsr_d    = SEED;
               misr_d    = 16'h0000;
               pass_d    = 1'b0;
               bit_cnt_d = '0;
               pat_cnt_d = '0;
            end
         end
         S_SHIFT: begin
            lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            // The very first unload carries unknown chain contents.
            misr_en = (pat_cnt_q != '0);
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               state_d   = S_CAPTURE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            pat_cnt_d = pat_cnt_q + 1'b1;
            state_d   = (pat_cnt_d == PAT_LAST) ? S_FLUSH : S_SHIFT;
         end
         S_FLUSH: begin
            misr_en = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               state_d   = S_COMPARE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_COMPARE: begin
            pass_d  = (misr_q == golden_sig);
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (misr_en) begin
         misr_d = {misr_q[14:0],
                   misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10] ^ scan_out};
      end

      // Abort freezes LFSR/MISR for inspection but discards the verdict.
      if (abort_req && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         lfsr_d    = lfsr_q;
         misr_d    = misr_q;
         pass_d    = 1'b0;
         bit_cnt_d = '0;
         pat_cnt_d = '0;
      end

      scan_en_d = (state_d == S_SHIFT) || (state_d == S_FLUSH);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED;
         misr_q    <= 16'h0000;
         bit_cnt_q <= '0;
         pat_cnt_q <= '0;
         scan_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         misr_q    <= misr_d;
         bit_cnt_q <= bit_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         scan_en_q <= scan_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   assign scan_in   = (state_q == S_SHIFT) ? lfsr_q[15] : 1'b0;
   assign scan_en   = scan_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = misr_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_bist_ctrl.sv
// ============================================================================
// tb_scan_bist_ctrl : bench for scan_bist_ctrl (small config + default config
//                     with a behavioural scan chain). Honours BIST_ABORT_EN.
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_bist_ctrl;

   localparam int          S_CL   = 4;
   localparam int          S_NP   = 2;
   localparam int          S_LEN  = S_NP * (S_CL + 1) + S_CL + 2;
   localparam int          D_NP   = 32;
   localparam int          D_LEN  = D_NP * 17 + 16 + 2;
   localparam logic [15:0] SEED_V = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, s_start, s_scan_out, d_start;
   logic [15:0] s_gold, d_gold;
   logic        s_scan_in, s_scan_en, s_busy, s_done, s_pass;
   logic        d_scan_in, d_scan_en, d_busy, d_done, d_pass;
   logic [15:0] s_sig, d_sig;
   logic        d_scan_out;
`ifdef BIST_ABORT_EN
   logic        s_abort, d_abort;
`endif

   int vectors     = 0;
   int miscompares = 0;

   scan_bist_ctrl #(.CHAIN_LEN(S_CL), .NUM_PATTERNS(S_NP), .SEED(SEED_V)) dut_small (
      .clk(clk), .reset(reset), .start(s_start), .golden_sig(s_gold), .scan_out(s_scan_out),
`ifdef BIST_ABORT_EN
      .abort(s_abort),
`endif
      .scan_in(s_scan_in), .scan_en(s_scan_en), .busy(s_busy), .done(s_done),
      .pass(s_pass), .signature(s_sig)
   );

   scan_bist_ctrl dut_def (
      .clk(clk), .reset(reset), .start(d_start), .golden_sig(d_gold), .scan_out(d_scan_out),
`ifdef BIST_ABORT_EN
      .abort(d_abort),
`endif
      .scan_in(d_scan_in), .scan_en(d_scan_en), .busy(d_busy), .done(d_done),
      .pass(d_pass), .signature(d_sig)
   );

   // Behavioural 16-flop scan chain: shifts when scan_en, otherwise captures
   // its inverted contents (optionally with one bit flipped in one pattern).
   logic [15:0] chain, chain_seed;
   int          cap_cnt;
   bit          flip_en;
   int          flip_pat, flip_bit;

   always @(posedge clk) begin
      if (!d_busy) begin
         chain   <= chain_seed;
         cap_cnt <= 0;
      end else if (d_scan_en) begin
         chain <= {chain[14:0], d_scan_in};
      end else begin
         chain   <= ~chain ^ ((flip_en && cap_cnt == flip_pat) ? (16'h1 << flip_bit) : 16'h0);
         cap_cnt <= cap_cnt + 1;
      end
   end
   assign d_scan_out = chain[15];

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic b);
      return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ b};
   endfunction

   // Cycle offsets k relative to the start cycle T, small configuration.
   function automatic bit is_shift(input int k);
      return (k >= 1) && (k <= S_NP * (S_CL + 1)) && ((k % (S_CL + 1)) != 0);
   endfunction

   function automatic bit is_flush(input int k);
      return (k > S_NP * (S_CL + 1)) && (k <= S_NP * (S_CL + 1) + S_CL);
   endfunction

   function automatic bit misr_on(input int k);
      return (is_shift(k) && k > S_CL + 1) || is_flush(k);
   endfunction

   // Expected default-config signature: each pattern's captured (inverted)
   // load is unloaded MSB first into the MISR; pattern 0's unload is skipped.
   function automatic logic [15:0] ref_sig(input int fp, input int fb);
      logic [15:0] l, m, v;
      l = SEED_V;
      m = 16'h0000;
      for (int p = 0; p < D_NP; p++) begin
         v = 16'h0000;
         for (int i = 0; i < 16; i++) begin
            v = {v[14:0], l[15]};
            l = lfsr_step(l);
         end
         v = ~v;
         if (p == fp) v[fb] = ~v[fb];
         for (int i = 15; i >= 0; i--) m = misr_step(m, v[i]);
      end
      return m;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({s_scan_in, s_scan_en, s_busy, s_done, s_pass, s_sig} !== 21'h0) begin
         miscompares++;
         $display("FAIL reset_small got %h exp 0", {s_scan_in, s_scan_en, s_busy, s_done, s_pass, s_sig});
      end
      vectors++;
      if ({d_scan_in, d_scan_en, d_busy, d_done, d_pass, d_sig} !== 21'h0) begin
         miscompares++;
         $display("FAIL reset_default got %h exp 0", {d_scan_in, d_scan_en, d_busy, d_done, d_pass, d_sig});
      end
      reset = 1'b0;
   endtask

   task automatic test_small_runs();
      logic [15:0] ml, ms, gold;
      bit          so [0:S_LEN+1];
      bit          exp_pass, e_se, e_si;
      int          repulse;
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k <= S_LEN + 1; k++) so[k] = (it < 2) ? 1'b0 : 1'($urandom_range(0, 1));
         ms = 16'h0000;
         for (int k = 1; k <= S_LEN; k++) if (misr_on(k)) ms = misr_step(ms, so[k]);
         if (it == 0)          gold = 16'h0000;
         else if (it == 1)     gold = 16'h0001;
         else if (it % 2 == 0) gold = ms;
         else                  gold = ms ^ 16'($urandom_range(1, 65535));
         exp_pass = (gold == ms);
         repulse  = $urandom_range(2, 14);

         @(negedge clk);
         s_start = 1'b1; s_gold = gold; s_scan_out = so[0];
         ml = SEED_V;
         ms = 16'h0000;
         for (int k = 1; k <= S_LEN + 1; k++) begin
            @(negedge clk);
            s_start    = (k == repulse);
            s_scan_out = so[k];
            e_se = is_shift(k) || is_flush(k);
            e_si = is_shift(k) ? ml[15] : 1'b0;
            vectors++;
            if (s_scan_en !== e_se) begin
               miscompares++;
               $display("FAIL scan_en run=%0d k=%0d got %b exp %b", it, k, s_scan_en, e_se);
            end
            vectors++;
            if (s_scan_in !== e_si) begin
               miscompares++;
               $display("FAIL scan_in run=%0d k=%0d got %b exp %b", it, k, s_scan_in, e_si);
            end
            vectors++;
            if (s_busy !== (k <= S_LEN)) begin
               miscompares++;
               $display("FAIL busy run=%0d k=%0d got %b exp %b", it, k, s_busy, (k <= S_LEN));
            end
            vectors++;
            if (s_done !== (k == S_LEN)) begin
               miscompares++;
               $display("FAIL done run=%0d k=%0d got %b exp %b", it, k, s_done, (k == S_LEN));
            end
            vectors++;
            if (s_sig !== ms) begin
               miscompares++;
               $display("FAIL signature run=%0d k=%0d got %h exp %h", it, k, s_sig, ms);
            end
            if (k == 1 || k >= S_LEN) begin
               vectors++;
               if (s_pass !== ((k == 1) ? 1'b0 : exp_pass)) begin
                  miscompares++;
                  $display("FAIL pass run=%0d k=%0d got %b exp %b", it, k, s_pass,
                           (k == 1) ? 1'b0 : exp_pass);
               end
            end
            if (is_shift(k)) ml = lfsr_step(ml);
            if (misr_on(k))  ms = misr_step(ms, so[k]);
         end
         s_start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      bit e_busy, e_done;
      s_scan_out = 1'b0; s_gold = 16'h0000;
      @(negedge clk);
      s_start = 1'b1;
      for (int k = 1; k <= 2 * S_LEN + 2; k++) begin
         @(negedge clk);
         if (k == S_LEN + 2) s_start = 1'b0;
         e_busy = (k <= S_LEN) || (k >= S_LEN + 2 && k <= 2 * S_LEN + 1);
         e_done = (k == S_LEN) || (k == 2 * S_LEN + 1);
         vectors++;
         if (s_busy !== e_busy || s_done !== e_done) begin
            miscompares++;
            $display("FAIL b2b_busy_done k=%0d got %b%b exp %b%b", k, s_busy, s_done, e_busy, e_done);
         end
         if (k == 2 * S_LEN + 1) begin
            vectors++;
            if (s_pass !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_pass got %b exp 1", s_pass);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int rc [2] = '{3, 12};
      for (int r = 0; r < 2; r++) begin
         s_gold = 16'h0000;
         @(negedge clk);
         s_start = 1'b1;
         for (int k = 1; k <= rc[r] + 20; k++) begin
            @(negedge clk);
            s_start    = 1'b0;
            s_scan_out = 1'($urandom_range(0, 1));
            reset      = (k == rc[r]);
            if (k == rc[r] + 1) begin
               vectors++;
               if ({s_busy, s_scan_en, s_pass, s_done, s_sig} !== 20'h0) begin
                  miscompares++;
                  $display("FAIL reset_midrun at=%0d got %h exp 0", rc[r],
                           {s_busy, s_scan_en, s_pass, s_done, s_sig});
               end
            end else if (k > rc[r] + 1) begin
               vectors++;
               if (s_done !== 1'b0 || s_busy !== 1'b0) begin
                  miscompares++;
                  $display("FAIL reset_no_done at=%0d k=%0d got %b%b exp 00", rc[r], k, s_done, s_busy);
               end
            end
         end
      end
   endtask

   task automatic test_chain_default();
      logic [15:0] exp_sig;
      int          done_at;
      for (int f = 0; f < 2; f++) begin
         flip_en    = (f == 1);
         flip_pat   = 7;
         flip_bit   = $urandom_range(0, 15);
         chain_seed = 16'($urandom);
         exp_sig    = ref_sig(flip_en ? 7 : -1, flip_bit);
         d_gold     = ref_sig(-1, 0);
         @(negedge clk);
         d_start = 1'b1;
         done_at = -1;
         for (int k = 1; k <= D_LEN + 5; k++) begin
            @(negedge clk);
            d_start = 1'b0;
            if (d_done === 1'b1 && done_at < 0) done_at = k;
         end
         vectors++;
         if (done_at != D_LEN) begin
            miscompares++;
            $display("FAIL chain_done_cycle flip=%0d got %0d exp %0d", f, done_at, D_LEN);
         end
         vectors++;
         if (d_sig !== exp_sig) begin
            miscompares++;
            $display("FAIL chain_signature flip=%0d got %h exp %h", f, d_sig, exp_sig);
         end
         vectors++;
         if (d_pass !== (f == 0)) begin
            miscompares++;
            $display("FAIL chain_pass flip=%0d got %b exp %b", f, d_pass, (f == 0));
         end
      end
   endtask

`ifdef BIST_ABORT_EN
   task automatic test_abort();
      logic [15:0] ms;
      bit          so6;
      s_gold = 16'h0000;
      ms     = 16'h0000;
      so6    = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         s_start    = 1'b0;
         s_scan_out = 1'($urandom_range(0, 1));
         if (k == 6) so6 = s_scan_out;
         s_abort = (k == 7);
         if (k == 8) begin
            ms = misr_step(16'h0000, so6);
            vectors++;
            if ({s_busy, s_scan_en, s_pass, s_done} !== 4'b0 || s_sig !== ms) begin
               miscompares++;
               $display("FAIL abort_state got %b sig %h exp 0000 sig %h",
                        {s_busy, s_scan_en, s_pass, s_done}, s_sig, ms);
            end
         end else if (k > 8) begin
            vectors++;
            if (s_done !== 1'b0) begin
               miscompares++;
               $display("FAIL abort_no_done k=%0d got %b exp 0", k, s_done);
            end
         end
      end
      s_scan_out = 1'b0;
      @(negedge clk);
      s_start = 1'b1;
      for (int k = 1; k <= S_LEN; k++) begin
         @(negedge clk);
         s_start = 1'b0;
      end
      vectors++;
      if (s_done !== 1'b1 || s_pass !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_rerun got done=%b pass=%b exp 1 1", s_done, s_pass);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; s_start = 1'b0; d_start = 1'b0; s_scan_out = 1'b0;
      s_gold = 16'h0000; d_gold = 16'h0000;
      chain_seed = 16'h0000; flip_en = 1'b0; flip_pat = 0; flip_bit = 0;
`ifdef BIST_ABORT_EN
      s_abort = 1'b0; d_abort = 1'b0;
`endif
      test_reset();
      test_small_runs();
      test_back_to_back();
      test_reset_midrun();
      test_chain_default();
`ifdef BIST_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
